// File: rtl/pkg_alu.sv
// rtl/pkg_alu.sv - opcodes of the shared 8-bit ALU
package pkg_alu;
  typedef enum logic [2:0] {
    alu_op_add  = 3'd0,
    alu_op_adc  = 3'd1,
    alu_op_sub  = 3'd2,
    alu_op_sbc  = 3'd3,
    alu_op_and  = 3'd4,
    alu_op_or   = 3'd5,
    alu_op_xor  = 3'd6,
    alu_op_pass = 3'd7
  } alu_oper;
endpackage

// File: rtl/pkg_alu_seq.sv
// rtl/pkg_alu_seq.sv - request opcodes, states and constants of the ALU sequencer
package pkg_alu_seq;
  typedef enum logic [2:0] {
    ADDP = 3'd0,
    SUBP = 3'd1,
    CMPP = 3'd2,
    MUL  = 3'd3
  } seq_oper;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } seq_state;

  localparam int SEQ_MUL_ITERS = 8;
endpackage

// File: rtl/pkg_pflags.sv
// rtl/pkg_pflags.sv - processor flag vector layout
package pkg_pflags;
  localparam int proc_flags_msb_pos = 3;
  localparam int pf_slot_c = 0;
  localparam int pf_slot_z = 1;
endpackage

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-pass 16-bit add/sub/cmp and 8x8 multiply on the shared 8-bit ALU
module alu_seq_ctrl
  import pkg_alu_seq::*;
#(
  parameter int FLAGS_W = pkg_pflags::proc_flags_msb_pos + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  seq_oper              req_op,
  input  logic [15:0]          req_a,
  input  logic [15:0]          req_b,
  input  logic [FLAGS_W-1:0]   req_flags,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_data,
  output logic [FLAGS_W-1:0]   res_flags,
  output logic                 alu_busy,
  output pkg_alu::alu_oper     alu_oper,
  output logic [7:0]           alu_a_lo,
  output logic [7:0]           alu_a_hi,
  output logic [7:0]           alu_b,
  output logic [FLAGS_W-1:0]   alu_flags_in,
  input  logic [7:0]           alu_out_lo,
  input  logic [FLAGS_W-1:0]   alu_flags_out
);
  localparam int SLOT_C = pkg_pflags::pf_slot_c;
  localparam int SLOT_Z = pkg_pflags::pf_slot_z;
  localparam logic [2:0] LAST_ITER = 3'(SEQ_MUL_ITERS - 1);

  seq_state             r_state;
  seq_oper              r_op;
  logic [15:0]          r_a;
  logic [15:0]          r_b;
  logic [FLAGS_W-1:0]   r_flags;
  logic [7:0]           r_lo;
  logic                 r_c_lo;
  logic                 r_z_lo;
  logic [7:0]           r_prod_hi;
  logic [7:0]           r_prod_lo;
  logic [7:0]           r_mplier;
  logic [2:0]           r_cnt;
  logic [15:0]          r_res_data;
  logic [FLAGS_W-1:0]   r_res_flags;

  logic                 w_alu_c;
  logic                 w_alu_z;
  logic [16:0]          w_mul_next;
  logic [FLAGS_W-1:0]   w_flags_hi;
  logic [FLAGS_W-1:0]   w_flags_mul;
  logic                 w_unused_alu_flags;

  assign w_alu_c = alu_flags_out[SLOT_C];
  assign w_alu_z = alu_flags_out[SLOT_Z];
  assign w_unused_alu_flags = ^alu_flags_out;

  // Shift-add step: the ALU adds the multiplicand into prod_hi, carry-out becomes bit 16.
  assign w_mul_next = {w_alu_c, alu_out_lo, r_prod_lo} >> 1;

  always_comb begin
    w_flags_hi = r_flags;
    w_flags_hi[SLOT_C] = w_alu_c;
    w_flags_hi[SLOT_Z] = r_z_lo & w_alu_z;
    w_flags_mul = r_flags;
    w_flags_mul[SLOT_C] = 1'b0;
    w_flags_mul[SLOT_Z] = (w_mul_next[15:0] == 16'h0000);
  end

  assign req_ready = (r_state == ST_IDLE);
  assign res_valid = (r_state == ST_DONE);
  assign alu_busy  = (r_state == ST_LO) || (r_state == ST_HI) || (r_state == ST_MUL);
  assign res_data  = r_res_data;
  assign res_flags = r_res_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= ADDP;
      r_a         <= '0;
      r_b         <= '0;
      r_flags     <= '0;
      r_lo        <= '0;
      r_c_lo      <= 1'b0;
      r_z_lo      <= 1'b0;
      r_prod_hi   <= '0;
      r_prod_lo   <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_a     <= req_a;
            r_b     <= req_b;
            r_flags <= req_flags;
            case (req_op)
              ADDP, SUBP, CMPP: r_state <= ST_LO;
              MUL: begin
                r_prod_hi <= '0;
                r_prod_lo <= '0;
                r_mplier  <= req_b[7:0];
                r_cnt     <= '0;
                r_state   <= ST_MUL;
              end
              default: begin
                r_res_data  <= req_a;
                r_res_flags <= req_flags;
                r_state     <= ST_DONE;
              end
            endcase
          end
        end
        ST_LO: begin
          r_lo    <= alu_out_lo;
          r_c_lo  <= w_alu_c;
          r_z_lo  <= w_alu_z;
          r_state <= ST_HI;
        end
        ST_HI: begin
          r_res_data  <= (r_op == CMPP) ? r_a : {alu_out_lo, r_lo};
          r_res_flags <= w_flags_hi;
          r_state     <= ST_DONE;
        end
        ST_MUL: begin
          {r_prod_hi, r_prod_lo} <= w_mul_next[15:0];
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == LAST_ITER) begin
            r_res_data  <= w_mul_next[15:0];
            r_res_flags <= w_flags_mul;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Byte-wide passes only use the low A port; alu_a_hi stays parked at zero.
  always_comb begin
    alu_oper     = pkg_alu::alu_op_add;
    alu_a_lo     = 8'h00;
    alu_a_hi     = 8'h00;
    alu_b        = 8'h00;
    alu_flags_in = '0;
    case (r_state)
      ST_LO: begin
        alu_oper     = (r_op == ADDP) ? pkg_alu::alu_op_add : pkg_alu::alu_op_sub;
        alu_a_lo     = r_a[7:0];
        alu_b        = r_b[7:0];
        alu_flags_in = r_flags;
      end
      ST_HI: begin
        alu_oper     = (r_op == ADDP) ? pkg_alu::alu_op_adc : pkg_alu::alu_op_sbc;
        alu_a_lo     = r_a[15:8];
        alu_b        = r_b[15:8];
        alu_flags_in = r_flags;
        alu_flags_in[SLOT_C] = r_c_lo;
      end
      ST_MUL: begin
        alu_a_lo     = r_prod_hi;
        alu_b        = r_mplier[0] ? r_a[7:0] : 8'h00;
        alu_flags_in = r_flags;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized and directed checks of alu_seq_ctrl with a behavioural ALU
module tb_alu_seq_ctrl;
  localparam int FW = pkg_pflags::proc_flags_msb_pos + 1;
  localparam int SC = pkg_pflags::pf_slot_c;
  localparam int SZ = pkg_pflags::pf_slot_z;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  pkg_alu_seq::seq_oper  req_op = pkg_alu_seq::ADDP;
  logic [15:0]           req_a = '0;
  logic [15:0]           req_b = '0;
  logic [FW-1:0]         req_flags = '0;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic [15:0]           res_data;
  logic [FW-1:0]         res_flags;
  logic                  alu_busy;
  pkg_alu::alu_oper      alu_op_s;
  logic [7:0]            alu_a_lo;
  logic [7:0]            alu_a_hi;
  logic [7:0]            alu_b;
  logic [FW-1:0]         alu_flags_in;
  logic [7:0]            alu_out_lo;
  logic [FW-1:0]         alu_flags_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.FLAGS_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .alu_busy(alu_busy), .alu_oper(alu_op_s),
    .alu_a_lo(alu_a_lo), .alu_a_hi(alu_a_hi), .alu_b(alu_b),
    .alu_flags_in(alu_flags_in), .alu_out_lo(alu_out_lo), .alu_flags_out(alu_flags_out)
  );

  // Behavioural 8-bit ALU; SUB/SBC carry=1 means no borrow.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'd0;
    case (alu_op_s)
      pkg_alu::alu_op_add: alu_sum = {1'b0, alu_a_lo} + {1'b0, alu_b};
      pkg_alu::alu_op_adc: alu_sum = {1'b0, alu_a_lo} + {1'b0, alu_b} + 9'(alu_flags_in[SC]);
      pkg_alu::alu_op_sub: alu_sum = {1'b0, alu_a_lo} + {1'b0, ~alu_b} + 9'd1;
      pkg_alu::alu_op_sbc: alu_sum = {1'b0, alu_a_lo} + {1'b0, ~alu_b} + 9'(alu_flags_in[SC]);
      default:             alu_sum = 9'd0;
    endcase
    alu_out_lo = alu_sum[7:0];
    alu_flags_out = alu_flags_in;
    alu_flags_out[SC] = alu_sum[8];
    alu_flags_out[SZ] = (alu_sum[7:0] == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [FW-1:0] f, output logic [15:0] d,
                           output logic [FW-1:0] ef, output int lat, output int busy);
    int unsigned r;
    logic c, z;
    ef = f;
    case (op)
      3'd0: begin
        r = 32'(a) + 32'(b);
        d = r[15:0]; c = r[16]; z = (d == 16'h0);
        lat = 3; busy = 2;
      end
      3'd1, 3'd2: begin
        d = a - b; c = (a >= b); z = (a == b);
        if (op == 3'd2) d = a;
        lat = 3; busy = 2;
      end
      3'd3: begin
        r = 32'(a[7:0]) * 32'(b[7:0]);
        d = r[15:0]; c = 1'b0; z = (r == 0);
        lat = 9; busy = 8;
      end
      default: begin
        d = a; c = f[SC]; z = f[SZ];
        lat = 1; busy = 0;
      end
    endcase
    ef[SC] = c;
    ef[SZ] = z;
  endtask

  // Starts at a negedge with the block idle; returns at the negedge after the result handshake.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [FW-1:0] f, input int hold);
    logic [15:0] ed;
    logic [FW-1:0] ef;
    int elat, ebusy, lat, busy;
    ref_model(op, a, b, f, ed, ef, elat, ebusy);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op = pkg_alu_seq::seq_oper'(op);
    req_a = a;
    req_b = b;
    req_flags = f;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    busy = 0;
    while (!res_valid && lat < 20) begin
      if (alu_busy) busy++;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("busy_cycles", 32'(busy), 32'(ebusy));
    chk("res_data", 32'(res_data), 32'(ed));
    chk("res_flags", 32'(res_flags), 32'(ef));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_data", 32'(res_data), 32'(ed));
      chk("hold_flags", 32'(res_flags), 32'(ef));
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_after_hs", 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] op;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_alu_busy", 32'(alu_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'd0, 16'h12FF, 16'h0001, 4'b0000, 0);
    do_op(3'd0, 16'hFFFF, 16'h0001, 4'b1100, 0);
    do_op(3'd1, 16'h1000, 16'h0001, 4'b0101, 0);
    do_op(3'd2, 16'h0005, 16'h0006, 4'b1010, 0);
    do_op(3'd2, 16'h8080, 16'h8080, 4'b0000, 0);
    do_op(3'd3, 16'h00FF, 16'h00FF, 4'b1100, 0);
    do_op(3'd3, 16'hAB00, 16'h5537, 4'b1011, 5);
    do_op(3'd5, 16'hBEEF, 16'h1234, 4'b1001, 1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 4));
      if (op == 3'd4) op = 3'($urandom_range(4, 7));
      do_op(op, 16'($urandom), 16'($urandom), FW'($urandom), int'($urandom_range(0, 2)));
    end

    // Abandon a multiply at iteration 4 with an asynchronous reset.
    req_valid = 1'b1;
    req_op = pkg_alu_seq::MUL;
    req_a = 16'h00FF;
    req_b = 16'h00FF;
    req_flags = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mul_busy_pre_rst", 32'(alu_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_data", 32'(res_data), 32'd0);
    chk("arst_res_flags", 32'(res_flags), 32'd0);
    chk("arst_alu_busy", 32'(alu_busy), 32'd0);
    chk("arst_alu_ops", {alu_a_lo, alu_a_hi, alu_b, 5'(alu_flags_in), 3'(alu_op_s)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_result", 32'(res_valid), 32'd0);
    do_op(3'd0, 16'h0001, 16'h0001, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
